// File: rtl/pad_trig_pkg.sv
// pad_trig_pkg: shared pad-trigger constants, word/index types and emitter state encoding
package pad_trig_pkg;
  localparam int PAD_WIDTH = 104;
  localparam int PAD_IDX_W = 7;
  localparam int PAD_MAX_HITS_DEF = 8;
  typedef logic [PAD_WIDTH-1:0] pad_word_t;
  typedef logic [PAD_IDX_W-1:0] pad_idx_t;
  typedef enum logic {IDLE, EMIT} pad_state_t;
endpackage

// File: rtl/pad_lsb_encoder.sv
// pad_lsb_encoder: lowest-set-bit index of a vector with any/single-bit flags
module pad_lsb_encoder #(
  parameter int W = pad_trig_pkg::PAD_WIDTH,
  parameter int IW = pad_trig_pkg::PAD_IDX_W
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic          single
);
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) idx = vec[i] ? IW'(i) : idx;
  end
  assign any = |vec;
  assign single = any & ~|(vec & (vec - W'(1)));
endmodule

// File: rtl/pad_hit_encoder.sv
// pad_hit_encoder: streams set-bit indices of each pad word per frame; PAD_HIT_ENCODER_DROP_CNT_EN enables drop_cnt
module pad_hit_encoder #(
  parameter int PAD_WIDTH = pad_trig_pkg::PAD_WIDTH,
  parameter int IDX_W = pad_trig_pkg::PAD_IDX_W,
  parameter int MAX_HITS = pad_trig_pkg::PAD_MAX_HITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pad_hit_clear,
  input  logic [PAD_WIDTH-1:0] pad_data_syn,
  input  logic                 pad_data_valid_in,
  output logic [IDX_W-1:0]     hit_idx,
  output logic [7:0]           hit_frame_id,
  output logic                 hit_valid,
  input  logic                 hit_ready,
  output logic                 hit_last,
  output logic                 hit_overflow,
  output logic                 busy,
  output logic                 frame_drop,
  output logic [15:0]          drop_cnt
);
  import pad_trig_pkg::*;
  localparam int CW = $clog2(MAX_HITS + 1);
  pad_state_t state, state_nx;
  logic [PAD_WIDTH-1:0] work;
  logic [CW-1:0] hit_cnt;
  logic [7:0] frame_id;
  logic [IDX_W-1:0] lsb;
  logic any, single, emit, last, fire, accept, drop;
  pad_lsb_encoder #(.W(PAD_WIDTH), .IW(IDX_W)) u_enc (
    .vec(work),
    .idx(lsb),
    .any(any),
    .single(single)
  );
  assign emit = state == EMIT;
  assign last = emit & (single | hit_cnt == CW'(MAX_HITS - 1));
  assign fire = emit & hit_ready;
  // a new word slips in only on the final handshake, giving bubble-free back-to-back frames
  assign accept = pad_data_valid_in & ~pad_hit_clear & (~emit | (fire & last));
  assign drop = pad_data_valid_in & ~pad_hit_clear & ~accept;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = pad_hit_clear ? IDLE : accept ? (|pad_data_syn ? EMIT : IDLE) : (fire & last) ? IDLE : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      work <= '0;
      hit_cnt <= '0;
      frame_id <= '0;
      frame_drop <= 1'b0;
    end else begin
      frame_drop <= drop;
      frame_id <= accept ? frame_id + 8'd1 : frame_id;
      hit_cnt <= (pad_hit_clear | accept) ? '0 : fire ? hit_cnt + CW'(1) : hit_cnt;
      work <= pad_hit_clear ? '0 : accept ? pad_data_syn : (fire & last) ? '0 :
              fire ? work & ~(PAD_WIDTH'(1) << lsb) : work;
    end
  always_comb begin
    hit_valid = emit;
    busy = emit;
    hit_idx = emit ? lsb : '0;
    hit_frame_id = frame_id;
    hit_last = last;
    hit_overflow = last & any & ~single;
  end
`ifdef PAD_HIT_ENCODER_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
`else
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_pad_hit_encoder.sv
// tb_pad_hit_encoder: randomized and directed checks against a frame-level queue model
module tb_pad_hit_encoder;
  localparam int PW = 104, IW = 7, MH = 8;
  logic clk = 0, rst_n = 0, pad_hit_clear = 0, pad_data_valid_in = 0, hit_ready = 0;
  logic [PW-1:0] pad_data_syn = '0;
  logic [IW-1:0] hit_idx;
  logic [7:0] hit_frame_id;
  logic hit_valid, hit_last, hit_overflow, busy, frame_drop;
  logic [15:0] drop_cnt;
  int total = 0, bad = 0;
  int q[$];
  bit m_ovf = 0, m_pulse = 0;
  int m_fid = 0, m_drop = 0;
  always #5 clk = ~clk;
  pad_hit_encoder #(.PAD_WIDTH(PW), .IDX_W(IW), .MAX_HITS(MH)) dut (
    .clk(clk), .rst_n(rst_n), .pad_hit_clear(pad_hit_clear), .pad_data_syn(pad_data_syn),
    .pad_data_valid_in(pad_data_valid_in), .hit_idx(hit_idx), .hit_frame_id(hit_frame_id),
    .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_last(hit_last), .hit_overflow(hit_overflow),
    .busy(busy), .frame_drop(frame_drop), .drop_cnt(drop_cnt)
  );
  // frame model: a queue of the indices still to be sent for the current frame
  task automatic model_step(input bit v, input logic [PW-1:0] d, input bit r, input bit c);
    bit fin, acc;
    if (c) begin
      q.delete();
      m_pulse = 0;
      return;
    end
    fin = q.size() == 1 && r;
    acc = v && (q.size() == 0 || fin);
    m_pulse = v && !acc;
    if (m_pulse && m_drop < 65535) m_drop++;
    if (q.size() > 0 && r) void'(q.pop_front());
    if (acc) begin
      int n;
      n = 0;
      m_fid = (m_fid + 1) % 256;
      for (int i = 0; i < PW; i++) if (d[i]) begin
        if (n < MH) q.push_back(i);
        n++;
      end
      m_ovf = n > MH;
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_fid = 0;
    m_drop = 0;
    m_pulse = 0;
    m_ovf = 0;
  endtask
  function automatic logic [35:0] exp_vec();
    logic [16:0] h;
    logic [15:0] cnt;
    bit v;
    v = q.size() > 0;
    h = '0;
`ifdef PAD_HIT_ENCODER_DROP_CNT_EN
    cnt = 16'(m_drop);
`else
    cnt = '0;
`endif
    if (v) h = {7'(q[0]), q.size() == 1, q.size() == 1 && m_ovf, 8'(m_fid)};
    return {v, v, m_pulse, cnt, h};
  endfunction
  function automatic logic [35:0] act_vec();
    return {hit_valid, busy, frame_drop, drop_cnt,
            hit_valid ? {hit_idx, hit_last, hit_overflow, hit_frame_id} : 17'd0};
  endfunction
  task automatic cycle(input bit v, input logic [PW-1:0] d, input bit r, input bit c);
    pad_data_valid_in = v;
    pad_data_syn = d;
    hit_ready = r;
    pad_hit_clear = c;
    @(posedge clk);
    model_step(v, d, r, c);
    @(negedge clk);
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (act_vec() !== 36'd0) begin bad++; $display("FAIL reset_held got=%h want=0", act_vec()); end
    rst_n = 1;
    @(negedge clk);
    total++;
    if (act_vec() !== exp_vec() || hit_idx !== '0) begin bad++; $display("FAIL reset_release got=%h want=%h", act_vec(), exp_vec()); end
  endtask
  task automatic test_three_bits();
    logic [PW-1:0] w;
    int e[3];
    e = '{3, 17, 103};
    w = '0;
    w[3] = 1; w[17] = 1; w[103] = 1;
    cycle(1, w, 1, 0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (act_vec() !== exp_vec()) begin bad++; $display("FAIL three_bits_model c%0d got=%h want=%h", i, act_vec(), exp_vec()); end
      total++;
      if (hit_valid !== 1'b1 || hit_idx !== IW'(e[i]) || hit_last !== (i == 2) || hit_overflow !== 1'b0 || hit_frame_id !== 8'd1) begin
        bad++; $display("FAIL three_bits c%0d got idx=%0d last=%b ovf=%b fid=%0d want idx=%0d fid=1", i, hit_idx, hit_last, hit_overflow, hit_frame_id, e[i]);
      end
      cycle(0, '0, 1, 0);
    end
    total++;
    if (hit_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL three_bits_idle got valid=%b busy=%b want 0", hit_valid, busy); end
  endtask
  task automatic test_all_bits();
    cycle(1, '1, 1, 0);
    for (int i = 0; i < MH; i++) begin
      total++;
      if (act_vec() !== exp_vec()) begin bad++; $display("FAIL all_bits_model c%0d got=%h want=%h", i, act_vec(), exp_vec()); end
      total++;
      if (hit_idx !== IW'(i) || hit_last !== (i == MH - 1) || hit_overflow !== (i == MH - 1)) begin
        bad++; $display("FAIL all_bits c%0d got idx=%0d last=%b ovf=%b want idx=%0d", i, hit_idx, hit_last, hit_overflow, i);
      end
      cycle(0, '0, 1, 0);
    end
    total++;
    if (hit_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL all_bits_idle got valid=%b busy=%b want 0", hit_valid, busy); end
  endtask
  task automatic test_stall();
    logic [PW-1:0] w;
    logic [IW-1:0] pi;
    int hs;
    bit pr, pv, r;
    w = '0;
    w[5] = 1; w[6] = 1;
    hs = 0; pr = 0; pv = 0; pi = '0;
    cycle(1, w, 0, 0);
    for (int i = 0; i < 8; i++) begin
      r = i[0];
      total++;
      if (act_vec() !== exp_vec()) begin bad++; $display("FAIL stall_model c%0d got=%h want=%h", i, act_vec(), exp_vec()); end
      if (pv && !pr && hit_valid) begin
        total++;
        if (hit_idx !== pi) begin bad++; $display("FAIL stall_hold c%0d got idx=%0d want %0d", i, hit_idx, pi); end
      end
      pv = hit_valid; pr = r; pi = hit_idx;
      if (hit_valid && r) hs++;
      cycle(0, '0, r, 0);
    end
    total++;
    if (hs != 2) begin bad++; $display("FAIL stall_handshakes got=%0d want=2", hs); end
  endtask
  task automatic test_drop();
    logic [PW-1:0] w, w2;
    int f0, d0;
    w = '0; w2 = '0;
    w[1] = 1; w[2] = 1; w[9] = 1;
    w2[40] = 1; w2[41] = 1;
    d0 = m_drop;
    cycle(1, w, 1, 0);
    f0 = m_fid;
    cycle(1, w2, 1, 0);
    total++;
    if (act_vec() !== exp_vec()) begin bad++; $display("FAIL drop_model got=%h want=%h", act_vec(), exp_vec()); end
    total++;
`ifdef PAD_HIT_ENCODER_DROP_CNT_EN
    if (frame_drop !== 1'b1 || drop_cnt !== 16'(d0 + 1)) begin bad++; $display("FAIL drop_pulse got drop=%b cnt=%0d want 1/%0d", frame_drop, drop_cnt, d0 + 1); end
`else
    if (frame_drop !== 1'b1 || drop_cnt !== 16'd0) begin bad++; $display("FAIL drop_pulse got drop=%b cnt=%0d want 1/0", frame_drop, drop_cnt); end
`endif
    cycle(0, '0, 1, 0);
    total++;
    if (act_vec() !== exp_vec() || hit_idx !== 7'd9 || hit_last !== 1'b1) begin bad++; $display("FAIL drop_last got=%h want=%h", act_vec(), exp_vec()); end
    cycle(1, w2, 1, 0);
    total++;
    if (hit_valid !== 1'b1 || hit_idx !== 7'd40 || hit_frame_id !== 8'(f0 + 1) || frame_drop !== 1'b0) begin
      bad++; $display("FAIL drop_b2b got valid=%b idx=%0d fid=%0d drop=%b want 1/40/%0d/0", hit_valid, hit_idx, hit_frame_id, frame_drop, f0 + 1);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (act_vec() !== exp_vec()) begin bad++; $display("FAIL drop_drain c%0d got=%h want=%h", i, act_vec(), exp_vec()); end
      cycle(0, '0, 1, 0);
    end
  endtask
  task automatic test_clear();
    logic [PW-1:0] w, w2;
    int f0;
    w = '0; w2 = '0;
    w[10] = 1; w[20] = 1; w[30] = 1; w[40] = 1;
    w2[50] = 1;
    cycle(1, w, 1, 0);
    f0 = m_fid;
    cycle(0, '0, 1, 0);
    total++;
    if (hit_idx !== 7'd20) begin bad++; $display("FAIL clear_second got idx=%0d want 20", hit_idx); end
    cycle(1, w, 1, 1);
    total++;
    if (hit_valid !== 1'b0 || busy !== 1'b0 || frame_drop !== 1'b0) begin bad++; $display("FAIL clear_abort got valid=%b busy=%b drop=%b want 0", hit_valid, busy, frame_drop); end
    cycle(0, '0, 1, 0);
    total++;
    if (act_vec() !== exp_vec()) begin bad++; $display("FAIL clear_idle got=%h want=%h", act_vec(), exp_vec()); end
    cycle(1, w2, 0, 0);
    total++;
    if (hit_valid !== 1'b1 || hit_idx !== 7'd50 || hit_frame_id !== 8'(f0 + 1)) begin
      bad++; $display("FAIL clear_next got valid=%b idx=%0d fid=%0d want 1/50/%0d", hit_valid, hit_idx, hit_frame_id, f0 + 1);
    end
    cycle(0, '0, 1, 0);
  endtask
  task automatic test_empty_wrap();
    logic [PW-1:0] w;
    int f0;
    w = '0;
    w[77] = 1;
    cycle(1, '0, 1, 0);
    total++;
    if (hit_valid !== 1'b0 || busy !== 1'b0 || act_vec() !== exp_vec()) begin bad++; $display("FAIL empty_word got=%h want=%h", act_vec(), exp_vec()); end
    f0 = m_fid;
    for (int i = 0; i < 256; i++) begin
      cycle(1, '0, 1, 0);
      total++;
      if (act_vec() !== exp_vec()) begin bad++; $display("FAIL wrap_model c%0d got=%h want=%h", i, act_vec(), exp_vec()); end
    end
    cycle(1, w, 1, 0);
    total++;
    if (hit_valid !== 1'b1 || hit_idx !== 7'd77 || hit_frame_id !== 8'(f0 + 1)) begin
      bad++; $display("FAIL wrap_fid got valid=%b idx=%0d fid=%0d want 1/77/%0d", hit_valid, hit_idx, hit_frame_id, (f0 + 1) % 256);
    end
    cycle(0, '0, 1, 0);
  endtask
  task automatic test_random();
    logic [PW-1:0] w;
    bit v, r, c;
    for (int i = 0; i < 3000; i++) begin
      w = '0;
      if ($urandom_range(0, 15) == 0) w = '1;
      else for (int k = $urandom_range(0, 12); k > 0; k--) w[$urandom_range(0, PW - 1)] = 1'b1;
      v = $urandom_range(0, 2) == 0;
      r = $urandom_range(0, 3) != 0;
      c = $urandom_range(0, 63) == 0;
      cycle(v, w, r, c);
      total++;
      if (act_vec() !== exp_vec()) begin bad++; $display("FAIL random c%0d got=%h want=%h", i, act_vec(), exp_vec()); end
    end
    cycle(0, '0, 1, 0);
  endtask
  task automatic test_reset_mid();
    logic [PW-1:0] w;
    w = '0;
    w[2] = 1; w[4] = 1; w[8] = 1; w[16] = 1; w[32] = 1;
    cycle(1, w, 1, 0);
    cycle(0, '0, 1, 0);
    rst_n = 0;
    #1;
    model_reset();
    total++;
    if (act_vec() !== 36'd0) begin bad++; $display("FAIL reset_mid got=%h want=0", act_vec()); end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      cycle(0, '0, 1, 0);
      total++;
      if (act_vec() !== exp_vec() || hit_valid !== 1'b0) begin bad++; $display("FAIL reset_after c%0d got=%h want=%h", i, act_vec(), exp_vec()); end
    end
  endtask
  initial begin
    test_reset();
    test_three_bits();
    test_all_bits();
    test_stall();
    test_drop();
    test_clear();
    test_empty_wrap();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
